regfile_cmd_master: RTL
=======================

Name: regfile_cmd_master

Overview:
- Command-driven initiator for the 32x32 two-read/one-write register file.
- Accepts one command at a time over a valid/ready interface: READ, WRITE, COPY or SWAP.
- Sequences the register file's read and write ports to carry out the command.
- Returns the pre-command register contents over a valid/ready response interface.
- Sits between a debug/control agent and the register file; reg30 side ports are not touched.

Parameters:
- ADDR_W, 5, register address width (32 registers).
- DATA_W, 32, register data width.
- ZERO_RO, 1, when 1 writes to address 0 are suppressed (rf_we held low).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_op  in  2  00 READ, 01 WRITE, 10 COPY, 11 SWAP.
- cmd_addr_a  in  ADDR_W  first register address.
- cmd_addr_b  in  ADDR_W  second register address.
- cmd_wdata  in  DATA_W  write data (WRITE only).
- rf_ra1  out  ADDR_W  register file read address 1.
- rf_ra2  out  ADDR_W  register file read address 2.
- rf_rd1  in  DATA_W  register file read data 1 (combinational read).
- rf_rd2  in  DATA_W  register file read data 2.
- rf_we  out  1  register file write enable.
- rf_wa  out  ADDR_W  register file write address.
- rf_wd  out  DATA_W  register file write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data1  out  DATA_W  pre-command value of reg[a].
- rsp_data2  out  DATA_W  READ/COPY/SWAP: pre-command reg[b]; WRITE: cmd_wdata.
- rsp_wskip  out  1  at least one write in this command was suppressed (address 0).

Behaviour:
- Reset (async, reset_n=0):
  - FSM to IDLE immediately.
  - cmd_ready=1 once in IDLE; rsp_valid=0, rf_we=0, rsp_wskip=0.
  - rsp_data1/2=0; rf_ra1/ra2/wa/wd=0.
  - A command in flight is abandoned: no further write, no response.
- States: IDLE, RD, WR1, WR2, RESP. rf_we is decoded from state (WR1/WR2 only), never registered.
- IDLE:
  - cmd_ready=1.
  - On edge with cmd_valid&cmd_ready: latch op, a, b, wdata -> RD.
  - cmd_valid while not ready is ignored; the command must be held by the sender.
- RD:
  - rf_ra1=a, rf_ra2=b.
  - At edge: capture d1=rf_rd1, d2=rf_rd2.
  - READ -> RESP; others -> WR1.
- WR1, address/data per op:
  - WRITE: wa=a, wd=wdata.
  - COPY: wa=b, wd=d1.
  - SWAP: wa=a, wd=d2.
  - The register file samples the write at the WR1->next edge.
  - SWAP -> WR2; others -> RESP.
- WR2 (SWAP only): wa=b, wd=d1 -> RESP.
- Zero register: if ZERO_RO=1 and wa=0 in WR1/WR2, rf_we=0 and a sticky wskip is set for the command. The sequence and timing are unchanged.
- RESP:
  - rsp_valid=1.
  - rsp_data1=d1.
  - rsp_data2 = wdata for WRITE, otherwise d2.
  - rsp fields are stable while rsp_valid.
  - On edge with rsp_ready -> IDLE; wskip is cleared on entry to RD.
- Latency, counting edge E0 as cmd accept:
  - rsp_valid rises after E1 for READ, E2 for WRITE/COPY, E3 for SWAP.
  - Register writes land at E2 (and E3 for SWAP).
- Throughput:
  - rsp_ready held high: next cmd accepted at the edge after the one that leaves RESP.
  - READ max 1 cmd / 3 cycles.
- Same-address cases:
  - a=b SWAP writes the same value twice; rsp_data1=rsp_data2.
  - a=b COPY is a no-op rewrite.
- rsp_ready asserted before rsp_valid has no effect.

Test Plan:
- Preload r5=0x11111111, r9=0x22222222; READ a=5 b=9 -> rsp_valid 1 cycle after accept; data1=0x11111111, data2=0x22222222; rf_we never high.
- WRITE a=7 wdata=0xDEADBEEF (r7=0) -> one rf_we pulse, wa=7, wd=0xDEADBEEF; rsp data1=0, data2=0xDEADBEEF; following READ a=7 returns 0xDEADBEEF.
- SWAP a=5 b=9 -> two rf_we cycles (5<-0x22222222, then 9<-0x11111111); rsp = 0x11111111/0x22222222; READ afterward shows values exchanged.
- WRITE a=0 wdata=0xFFFFFFFF, ZERO_RO=1 -> rf_we stays 0; rsp_wskip=1; READ a=0 unchanged.
- Hold rsp_ready=0 for 5 cycles after COPY a=3 b=4 -> rsp_valid and data stable, cmd_ready=0, extra cmd_valid ignored; rsp_ready=1 -> IDLE next edge, cmd_ready=1.
- Drop reset_n during WR1 of a SWAP -> rf_we falls immediately; no WR2 write; rsp_valid=0; cmd_ready=1; reg b unchanged.

Source files
------------

// File: rtl/regfile_cmd_master.sv
// Command-driven initiator for a 32x32 2R/1W register file.
// Runs READ/WRITE/COPY/SWAP and returns the pre-command register contents.
module regfile_cmd_master #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter bit ZERO_RO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
  output logic              rsp_wskip
);

  typedef enum logic [2:0] {IDLE, RD, WR1, WR2, RESP} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_COPY, OP_SWAP} op_t;

  state_t              state, state_nxt;
  op_t                 op_q;
  logic [ADDR_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   wdata_q, d1_q, d2_q;
  logic                wskip_q;
  logic                wr_active;
  logic                wr_zero;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = RD;
      RD:      state_nxt = (op_q == OP_READ) ? RESP : WR1;
      WR1:     state_nxt = (op_q == OP_SWAP) ? WR2 : RESP;
      WR2:     state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case
  // leaves a signal unassigned (which would infer a latch).
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_active = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    case (state)
      IDLE: cmd_ready = 1'b1;
      WR1: begin
        wr_active = 1'b1;
        case (op_q)
          OP_COPY: begin rf_wa = b_q; rf_wd = d1_q;    end
          OP_SWAP: begin rf_wa = a_q; rf_wd = d2_q;    end
          default: begin rf_wa = a_q; rf_wd = wdata_q; end
        endcase
      end
      WR2: begin
        wr_active = 1'b1;
        rf_wa     = b_q;
        rf_wd     = d1_q;
      end
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Write enable is decoded, not registered, so an async reset kills it at once.
  assign wr_zero = ZERO_RO && (rf_wa == '0);
  assign rf_we   = wr_active && !wr_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= OP_READ;
      a_q     <= '0;
      b_q     <= '0;
      wdata_q <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      wskip_q <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        op_q    <= op_t'(cmd_op);
        a_q     <= cmd_addr_a;
        b_q     <= cmd_addr_b;
        wdata_q <= cmd_wdata;
        wskip_q <= 1'b0;
      end
      if (state == RD) begin
        d1_q <= rf_rd1;
        d2_q <= rf_rd2;
      end
      // Sticky across WR1/WR2 so a suppressed first SWAP write is still reported.
      if (wr_active && wr_zero) wskip_q <= 1'b1;
    end
  end

  assign rf_ra1    = a_q;
  assign rf_ra2    = b_q;
  assign rsp_data1 = d1_q;
  assign rsp_data2 = (op_q == OP_WRITE) ? wdata_q : d2_q;
  assign rsp_wskip = wskip_q;

endmodule
